// File: rtl/rv32m_div_if.sv
// Request/response bundle between the execute stage and the rv32m_div iterative divider.
// The master side issues op/a/b and accepts results; the slave side is the divider.
interface rv32m_div_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] result;
  logic            div_by_zero;
  logic            busy;

  modport master (
    output req_valid, op, a, b, resp_ready,
    input  req_ready, resp_valid, result, div_by_zero, busy
  );

  modport slave (
    input  req_valid, op, a, b, resp_ready,
    output req_ready, resp_valid, result, div_by_zero, busy
  );
endinterface

// File: rtl/rv32m_div.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU with a valid/ready handshake.
// Optional macro RV32M_DIV_EARLY_OUT_EN adds a 1-cycle path when |a| < |b| and b != 0.
module rv32m_div #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic         clk,
  input  logic         rst,
  rv32m_div_if.slave   bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [XLEN-1:0] rem_reg;
  logic [XLEN-1:0] quo_reg;
  logic [XLEN-1:0] div_reg;
  logic            neg_q_reg;
  logic            neg_r_reg;
  logic            sel_rem_reg;
  logic [XLEN-1:0] result_reg;
  logic            dbz_reg;

  // Operand decode for the accept edge
  logic            op_signed;
  logic            op_rem;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            b_zero;
  logic            overflow;
  logic            early_out;
  logic            fast;
  logic [XLEN-1:0] fast_result;
  logic            accept;

  always_comb begin
    op_signed = ~bus.op[0];
    op_rem    = bus.op[1];
    a_neg     = op_signed & bus.a[XLEN-1];
    b_neg     = op_signed & bus.b[XLEN-1];
    a_mag     = a_neg ? (~bus.a + 1'b1) : bus.a;
    b_mag     = b_neg ? (~bus.b + 1'b1) : bus.b;
    b_zero    = (bus.b == '0);
    overflow  = op_signed && (bus.a == INT_MIN) && (bus.b == '1);
`ifdef RV32M_DIV_EARLY_OUT_EN
    early_out = !b_zero && (a_mag < b_mag);
`else
    early_out = 1'b0;
`endif
    fast      = b_zero | overflow | early_out;

    fast_result = '0;
    if (b_zero) begin
      fast_result = op_rem ? bus.a : '1;
    end else if (overflow) begin
      fast_result = op_rem ? '0 : INT_MIN;
    end else if (early_out) begin
      // Remainder keeps the original signed dividend, quotient is zero
      fast_result = op_rem ? bus.a : '0;
    end

    accept = bus.req_valid && (state_reg == IDLE);
  end

  // One restoring iteration on the magnitudes
  logic [XLEN:0]   rem_shift;
  logic [XLEN:0]   diff;
  logic            q_bit;
  logic [XLEN-1:0] rem_next;
  logic [XLEN-1:0] quo_next;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;
  logic [XLEN-1:0] final_result;
  logic            last_iter;

  always_comb begin
    rem_shift    = {rem_reg, quo_reg[XLEN-1]};
    diff         = rem_shift - {1'b0, div_reg};
    q_bit        = ~diff[XLEN];
    rem_next     = q_bit ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
    quo_next     = {quo_reg[XLEN-2:0], q_bit};
    quo_fix      = neg_q_reg ? (~quo_next + 1'b1) : quo_next;
    rem_fix      = neg_r_reg ? (~rem_next + 1'b1) : rem_next;
    final_result = sel_rem_reg ? rem_fix : quo_fix;
    last_iter    = (cnt_reg == CNT_W'(XLEN - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      rem_reg     <= '0;
      quo_reg     <= '0;
      div_reg     <= '0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      sel_rem_reg <= 1'b0;
      result_reg  <= '0;
      dbz_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            dbz_reg     <= b_zero;
            sel_rem_reg <= op_rem;
            neg_q_reg   <= a_neg ^ b_neg;
            neg_r_reg   <= a_neg;
            cnt_reg     <= '0;
            if (fast) begin
              result_reg <= fast_result;
              state_reg  <= DONE;
            end else begin
              rem_reg   <= '0;
              quo_reg   <= a_mag;
              div_reg   <= b_mag;
              state_reg <= CALC;
            end
          end
        end
        CALC: begin
          rem_reg <= rem_next;
          quo_reg <= quo_next;
          cnt_reg <= cnt_reg + 1'b1;
          if (last_iter) begin
            result_reg <= final_result;
            cnt_reg    <= '0;
            state_reg  <= DONE;
          end
        end
        DONE: begin
          if (bus.resp_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.req_ready   = (state_reg == IDLE);
  assign bus.resp_valid  = (state_reg == DONE);
  assign bus.busy        = (state_reg != IDLE);
  assign bus.result      = result_reg;
  assign bus.div_by_zero = dbz_reg;

endmodule

// File: tb/tb_rv32m_div.sv
// Randomised scoreboard bench for rv32m_div: driver pushes expected responses from a
// plain-arithmetic RV32M model, an independent monitor pops and compares on each response.
module tb_rv32m_div;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rv32m_div_if #(.XLEN(32)) bus ();

  rv32m_div #(.XLEN(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] res;
    logic        dbz;
    int          lat;
    time         t_acc;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   rr_mode = 0;
  int   n_tx = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // lat = clock edges after the accept edge before resp_valid is seen high
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output logic dbz, output int lat);
    logic [31:0] q;
    logic [31:0] r;
    logic [31:0] ma;
    logic [31:0] mb;
    logic        sgn;
    logic        fast;
    sgn  = !op[0];
    dbz  = 1'b0;
    fast = 1'b0;
    ma   = (sgn && a[31]) ? (32'd0 - a) : a;
    mb   = (sgn && b[31]) ? (32'd0 - b) : b;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; dbz = 1'b1; fast = 1'b1;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0; fast = 1'b1;
    end else if (sgn) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
`ifdef RV32M_DIV_EARLY_OUT_EN
    if (b != 32'd0 && ma < mb) fast = 1'b1;
`else
    if (ma == 32'd0 && mb == 32'd0) fast = fast;
`endif
    res = op[1] ? r : q;
    lat = fast ? 0 : 32;
  endfunction

  // resp_ready policy, changed just after each rising edge
  initial begin
    bus.resp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        0:       bus.resp_ready = 1'b1;
        1:       bus.resp_ready = ($urandom_range(0, 3) != 0);
        default: bus.resp_ready = 1'b0;
      endcase
    end
  end

  // Monitor
  initial begin
    bit seen;
    int lat;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 1'b0;
      end else if (bus.resp_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp actual=%h required=no_response", bus.result);
        end else begin
          if (!seen) begin
            lat = int'(($time - sb[0].t_acc - 5) / 10);
            check("latency", 32'(lat), 32'(sb[0].lat));
            check("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, sb[0].dbz});
            $display("resp op=%0d a=%h b=%h result=%h dbz=%0b lat=%0d", sb[0].op, sb[0].a, sb[0].b,
                     bus.result, bus.div_by_zero, lat);
            seen = 1'b1;
          end
          check("result", bus.result, sb[0].res);
          check("req_ready_in_done", {31'd0, bus.req_ready}, 32'd0);
          check("busy_in_done", {31'd0, bus.busy}, 32'd1);
          if (bus.resp_ready) begin
            void'(sb.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int   guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    while (!bus.req_ready && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.req_ready) begin
      checks++;
      errors++;
      $display("FAIL req_ready_timeout actual=0 required=1");
      return;
    end
    bus.op = op;
    bus.a = a;
    bus.b = b;
    bus.req_valid = 1'b1;
    @(posedge clk);
    model(op, a, b, e.res, e.dbz, e.lat);
    e.t_acc = $time;
    e.op = op;
    e.a = a;
    e.b = b;
    sb.push_back(e);
    n_tx++;
    #1;
    bus.req_valid = 1'b0;
    bus.op = 2'($urandom);
    bus.a = $urandom;
    bus.b = $urandom;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          guard;
    int          vcount;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.op = 2'd0;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_dbz", {31'd0, bus.div_by_zero}, 32'd0);

    issue(2'd1, 32'd100, 32'd7);
    issue(2'd3, 32'd100, 32'd7);
    issue(2'd0, 32'hFFFF_FFF9, 32'd2);
    issue(2'd2, 32'hFFFF_FFF9, 32'd2);
    issue(2'd0, 32'd7, 32'hFFFF_FFFE);
    issue(2'd1, 32'd123, 32'd0);
    issue(2'd2, 32'hFFFF_FFFB, 32'd0);
    issue(2'd0, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(2'd1, 32'd3, 32'd10);
    issue(2'd3, 32'hFFFF_FFFF, 32'd1);
    drain();

    // Backpressure: hold resp_ready low for 10 cycles of valid response
    rr_mode = 2;
    @(posedge clk);
    #2;
    issue(2'd1, 32'd100, 32'd7);
    guard = 0;
    @(negedge clk);
    while (!bus.resp_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("bp_resp_valid_seen", {31'd0, bus.resp_valid}, 32'd1);
    repeat (10) @(negedge clk);
    check("bp_still_valid", {31'd0, bus.resp_valid}, 32'd1);
    rr_mode = 0;
    @(posedge clk);
    #2;
    @(negedge clk);
    check("bp_release_done", {31'd0, bus.resp_valid}, 32'd1);
    @(negedge clk);
    check("bp_idle_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("bp_idle_busy", {31'd0, bus.busy}, 32'd0);
    drain();

    // Reset during iteration 15 abandons the division
    issue(2'd1, 32'd1000, 32'd3);
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check("midrst_result", bus.result, 32'd0);
    vcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.resp_valid) vcount++;
    end
    check("midrst_no_resp", 32'(vcount), 32'd0);

    // Random traffic with random response stalls
    rr_mode = 1;
    repeat (120) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 15);
        3: a = $urandom_range(0, 50);
        4: b = 32'd0 - $urandom_range(1, 15);
        default: ;
      endcase
      issue(op, a, b);
    end
    drain();
    rr_mode = 0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32m_div.md
Name: rv32m_div

Overview:
- Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Sits beside rv32i_alu in the execute stage. Where the ALU is purely combinational, this block is the multi-cycle responder to the same op/a/b operand interface.
- Uses a valid/ready request/response handshake so the pipeline can stall while a division is in flight.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 6, iteration counter width; must hold XLEN.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  operands valid
- req_ready  out  1  block can accept a request
- op  in  2  00=DIV, 01=DIVU, 10=REM, 11=REMU
- a  in  XLEN  dividend (rs1)
- b  in  XLEN  divisor (rs2)
- resp_valid  out  1  result valid
- resp_ready  in  1  consumer accepts result
- result  out  XLEN  quotient or remainder, selected by op
- div_by_zero  out  1  sticky for the current response: b was 0
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst=1 at a clk edge, any state): state=IDLE, req_ready=1, resp_valid=0, result=0, div_by_zero=0, busy=0, counter=0. A division in flight is abandoned with no response.
- States and transitions:
  - IDLE to CALC: on req_valid && req_ready, the accept edge E0.
  - IDLE to DONE: on acceptance when a fast-path case applies.
  - CALC: one quotient bit per edge, 32 iterations on edges E1..E32. At E32, the final sign fix-up and select are registered into result and state becomes DONE.
  - DONE: resp_valid=1 and result stable until resp_valid && resp_ready, then state returns to IDLE.
- req_ready=1 only in IDLE. There is no new acceptance in the same cycle a response is consumed; the next request is accepted at the earliest one edge later.
- Latency:
  - Normal path: resp_valid first high in the cycle after E32, i.e. 32 edges after accept.
  - Fast path: resp_valid high in the cycle after E0.
- Signed ops (DIV, REM):
  - Operands are converted to magnitudes at E0.
  - Quotient is negated if sign(a) != sign(b).
  - Remainder takes sign(a).
  - Truncating division, so the remainder magnitude is less than |b|.
- Fast-path cases, evaluated at E0:
  - b==0: quotient=0xFFFFFFFF, remainder=a, div_by_zero=1.
  - Signed overflow (op=DIV/REM, a=0x80000000, b=0xFFFFFFFF): quotient=0x80000000, remainder=0.
- Operand inputs are don't-care after E0; the block captures all operands internally.
- resp_ready held high in DONE: the response is consumed on the first DONE edge.
- resp_ready low: DONE holds indefinitely; busy=1, req_ready=0.
- div_by_zero is cleared when a new request is accepted.

Optional Feature:
- Macro RV32M_DIV_EARLY_OUT_EN.
- Defined: an additional fast path at E0 for the unsigned-magnitude case |a| < |b| with b != 0. Result is quotient=0 and remainder=a (the original signed value), delivered with 1-cycle latency like the other fast paths.
- Undefined: these cases take the full 32-iteration path and produce identical results.
- The counter, CALC path and all other behaviour are unchanged either way.

Test Plan:
- DIVU a=100, b=7, resp_ready=1 -> result=14, resp_valid first high 32 edges after accept; REMU with the same operands -> 2.
- DIV a=-7 (0xFFFFFFF9), b=2 -> 0xFFFFFFFD (-3); REM with the same operands -> 0xFFFFFFFF (-1); DIV a=7, b=-2 -> 0xFFFFFFFD.
- DIVU a=123, b=0 -> result=0xFFFFFFFF, div_by_zero=1, 1-cycle latency; REM a=-5, b=0 -> 0xFFFFFFFB.
- DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000, div_by_zero=0, 1-cycle latency; REM with the same operands -> 0.
- Backpressure: resp_ready=0 for 10 cycles after resp_valid -> result stable, req_ready=0 throughout; raising resp_ready -> IDLE on the next edge. In a separate run, assert rst at iteration 15 -> resp_valid never rises, req_ready=1 the cycle after reset.
- With RV32M_DIV_EARLY_OUT_EN: DIVU a=3, b=10 -> result=0, 1-cycle latency. Without the macro: same result after 32 edges.
